// File: rtl/xup_tri_bus_rx_if.sv
// Bundle of XUP shared-bus receive signals: remote enable/data in, FIFO head out.
interface xup_tri_bus_rx_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            bus_en_n;
    logic [SIZE-1:0] bus_data;
    logic [SIZE-1:0] data_out;
    logic            data_valid;
    logic            data_ready;
    logic [CW-1:0]   count;
    logic            overflow;

    modport slave (
        input  bus_en_n, bus_data, data_ready,
        output data_out, data_valid, count, overflow
    );

    modport master (
        output bus_en_n, bus_data, data_ready,
        input  data_out, data_valid, count, overflow
    );
endinterface

// File: rtl/xup_tri_bus_rx.sv
// Captures one settled word per remote-driver enable pulse into a small
// first-word-fall-through FIFO drained over valid/ready.
module xup_tri_bus_rx #(
    parameter int unsigned SIZE   = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    xup_tri_bus_rx_if.slave   bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNTW-1:0]   r_settle_cnt;
    logic [CNTW-1:0]   w_settle_cnt_next;
    logic              w_capture;

    logic [SIZE-1:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_data_valid;
    logic [SIZE-1:0]   r_data_out;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [AW-1:0]     w_rd_ptr_next;
    logic [CW-1:0]     w_count_next;
    logic [SIZE-1:0]   w_head_next;

    // Enable-tracking state register; reset parks in HOLD so an in-flight pulse is skipped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_settle_cnt_next = r_settle_cnt;
        w_capture         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.bus_en_n) begin
                    w_state_next      = ST_SETTLE;
                    w_settle_cnt_next = CNTW'(1);
                end
            end
            ST_SETTLE: begin
                if (bus.bus_en_n) begin
                    w_state_next = ST_IDLE;
                end else if (r_settle_cnt == CNTW'(SETTLE)) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end else begin
                    w_settle_cnt_next = r_settle_cnt + CNTW'(1);
                end
            end
            ST_HOLD: begin
                if (bus.bus_en_n) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_HOLD;
        endcase
    end

    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_pop         = r_data_valid && bus.data_ready;
    assign w_push        = w_capture && (!w_full || w_pop);
    assign w_drop        = w_capture && w_full && !w_pop;
    assign w_rd_ptr_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Next head word: the incoming word when it lands in the head slot, else storage.
    always_comb begin
        w_head_next = '0;
        if (w_count_next != '0) begin
            if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
                w_head_next = bus.bus_data;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.bus_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr     <= w_rd_ptr_next;
            r_count      <= w_count_next;
            r_data_valid <= (w_count_next != '0);
            r_data_out   <= w_head_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
endmodule
